fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the RISC-V core, sitting directly upstream of the instruction memory. It owns the program counter and drives it to the IMEM `pc` input. It captures the returned 32-bit instruction word into the IF/ID pipeline register. It also handles stall, branch/jump redirect, run-off-end halt and misaligned-target fault.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `IMEM_BYTES`, default 40: instruction memory size in bytes; the last fetchable address is IMEM_BYTES-4.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `pc`  out  32  current fetch address; drives IMEM `pc`.
- `inst`  in  32  instruction word from IMEM for `pc`, combinational, same cycle.
- `stall`  in  1  from the hazard unit; hold the PC and IF/ID.
- `redirect_valid`  in  1  from EX; a taken branch or jump was resolved.
- `redirect_target`  in  32  new fetch address.
- `id_pc`  out  32  IF/ID register: PC of the captured instruction.
- `id_inst`  out  32  IF/ID register: captured instruction word.
- `id_valid`  out  1  IF/ID register: entry holds a real instruction.
- `halted`  out  1  state is HALT.
- `fetch_fault`  out  1  sticky; state is FAULT.

## Operation
- Reset values (asynchronous, while `rst_n`=0):
  - `pc`=RESET_PC.
  - `id_pc`=0.
  - `id_inst`=NOP 32'h0000_0013.
  - `id_valid`=0, `halted`=0, `fetch_fault`=0.
  - State is BOOT.
- A bubble means `id_inst`=NOP, `id_valid`=0, and `id_pc` unchanged.
- Range check: `pc` is in range when `pc` <= IMEM_BYTES-4 (unsigned). The target is aligned when target[1:0]==0.
- Priority at each edge: redirect > stall > normal fetch. A redirect always flushes IF/ID, even if `stall`=1.
- States:
  - **BOOT**: the first cycle after reset release. `pc` holds RESET_PC and IF/ID takes a bubble. Goes to RUN unconditionally. A redirect in BOOT is ignored.
  - **RUN**:
    - Redirect, aligned target: `pc`<=target, bubble, stay RUN.
    - Redirect, misaligned target: bubble, `pc` held, go to FAULT.
    - Else if `stall`: `pc` and all IF/ID fields hold.
    - Else if in range: `id_pc`<=`pc`, `id_inst`<=`inst`, `id_valid`<=1, `pc`<=`pc`+4 (mod 2^32).
    - Else (out of range): bubble, `pc` held, go to HALT.
  - **HALT**: a bubble every cycle and `stall` is ignored. An aligned redirect sets `pc`<=target and goes to RUN; the range check applies at the next fetch. A misaligned redirect goes to FAULT.
  - **FAULT**: a bubble every cycle. All inputs are ignored until reset.
- `inst` is sampled only in RUN when the PC is in range, not redirected and not stalled. Otherwise its value (possibly X off-range) must not propagate.

## Timing
- `pc` is a register output with no combinational path from any input to `pc`.
- Fetch latency is 1 cycle: the instruction at `pc` appears on `id_*` after the next rising edge.
- Redirect penalty: the edge that samples the redirect produces one bubble in IF/ID. The target instruction appears in IF/ID one edge later.
- After reset release, the first valid IF/ID entry appears after the 2nd rising edge (BOOT, then RUN).
- `halted` and `fetch_fault` are registered and change on the same edge as the state.
- If reset is asserted mid-operation, all outputs take their reset values immediately, without waiting for a clock edge.

## Structure
- Shared package `riscv_pkg`: `XLEN`=32, `NOP_INST`=32'h0000_0013, and the fetch-state enum {BOOT, RUN, HALT, FAULT}.
- No sub-module is needed: PC register, next-PC mux and IF/ID register live in one module.
- IMEM is instantiated alongside this block at core level.

## Test plan
All scenarios run with IMEM holding `lw x15,8(x17)` (32'h0088A783) at 0x0, 32'h00179793 at 0x4, and `add x17,x15,x15` (32'h00F788B3) at 0x18.

1. **Reset release:** hold `rst_n` low 2 cycles, then release.
   - After edge 1: `pc`=0, `id_valid`=0.
   - After edge 2: `id_pc`=0, `id_inst`=32'h0088A783, `id_valid`=1, `pc`=4.
   - After edge 3: `id_inst`=32'h00179793.
2. **Stall:** at `pc`=8, hold `stall`=1 for 2 cycles. `pc` stays 8 and `id_pc`=4, `id_valid`=1 hold. Fetch resumes on release.
3. **Redirect with stall:** drive `redirect_valid`=1, target 0x18, with `stall`=1.
   - Next edge: `pc`=0x18, `id_valid`=0, `id_inst`=32'h13.
   - Following edge: `id_pc`=0x18, `id_inst`=32'h00F788B3.
4. **Run-off end:** with IMEM_BYTES=40, run to `pc`=0x28.
   - Next edge: `halted`=1, `pc` stays 0x28, `id_valid`=0 every cycle.
   - Redirect to 0x0: `halted`=0, and the instruction at 0x0 is refetched.
5. **Misaligned redirect:** in RUN, redirect to 0x1A.
   - `fetch_fault`=1, and `id_valid` stays 0 permanently.
   - A later redirect to 0x0 is ignored.
   - Reset clears the fault.
6. **Async reset mid-run:** drop `rst_n` between edges at `pc`=0xC. All outputs take their reset values within the same cycle, before the next edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions used by the fetch stage.
//   XLEN          : architectural register / address width
//   NOP_INST      : canonical NOP (addi x0,x0,0), injected as a pipeline bubble
//   fetch_state_e : fetch-stage control states
//   is_aligned()  : word-alignment test for fetch targets
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } fetch_state_e;

  // A fetch target is usable only when it lands on a 4-byte boundary.
  function automatic logic is_aligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives IMEM, and captures the returned
// word into the IF/ID pipeline register. Handles stall, redirect, run-off-end
// halt and misaligned-target fault.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   pc               : registered fetch address to IMEM
//   inst             : IMEM read data for pc (combinational)
//   stall            : hold PC and IF/ID
//   redirect_valid   : taken branch/jump from EX
//   redirect_target  : new fetch address
//   id_pc/id_inst/id_valid : IF/ID register
//   halted           : state is HALT
//   fetch_fault      : state is FAULT (sticky until reset)
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              IMEM_BYTES = 40
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] inst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_inst,
  output logic            id_valid,
  output logic            halted,
  output logic            fetch_fault
);

  localparam logic [XLEN-1:0] LAST_FETCH = XLEN'(IMEM_BYTES - 4);

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] r_id_pc;
  logic [XLEN-1:0] w_id_pc_nxt;
  logic [XLEN-1:0] r_id_inst;
  logic [XLEN-1:0] w_id_inst_nxt;
  logic            r_id_valid;
  logic            w_id_valid_nxt;
  logic            r_halted;
  logic            r_fault;
  logic            w_take;
  logic            w_bubble;
  logic            w_in_range;
  logic            w_tgt_aligned;

  assign w_in_range    = (r_pc <= LAST_FETCH);
  assign w_tgt_aligned = is_aligned(redirect_target);

  // Next-state and next-PC selection; priority is redirect > stall > fetch.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_take      = 1'b0;
    w_bubble    = 1'b0;
    case (r_state)
      BOOT: begin
        // Redirects are ignored here; PC stays at RESET_PC for the first fetch.
        w_bubble    = 1'b1;
        w_state_nxt = RUN;
      end
      RUN: begin
        if (redirect_valid) begin
          w_bubble = 1'b1;
          if (w_tgt_aligned) begin
            w_pc_nxt = redirect_target;
          end else begin
            w_state_nxt = FAULT;
          end
        end else if (stall) begin
          w_bubble = 1'b0;
        end else if (w_in_range) begin
          w_take   = 1'b1;
          w_pc_nxt = r_pc + 32'd4;
        end else begin
          w_bubble    = 1'b1;
          w_state_nxt = HALT;
        end
      end
      HALT: begin
        // Stall is ignored; only a redirect leaves HALT.
        w_bubble = 1'b1;
        if (redirect_valid) begin
          if (w_tgt_aligned) begin
            w_pc_nxt    = redirect_target;
            w_state_nxt = RUN;
          end else begin
            w_state_nxt = FAULT;
          end
        end else begin
          w_state_nxt = HALT;
        end
      end
      FAULT: begin
        w_bubble = 1'b1;
      end
      default: begin
        w_bubble    = 1'b1;
        w_state_nxt = FAULT;
      end
    endcase
  end

  // IF/ID next value: capture, bubble (id_pc kept), or hold on stall.
  // inst is only routed through on a real capture so off-range X never lands.
  always_comb begin
    w_id_pc_nxt    = r_id_pc;
    w_id_inst_nxt  = r_id_inst;
    w_id_valid_nxt = r_id_valid;
    if (w_take) begin
      w_id_pc_nxt    = r_pc;
      w_id_inst_nxt  = inst;
      w_id_valid_nxt = 1'b1;
    end else if (w_bubble) begin
      w_id_inst_nxt  = NOP_INST;
      w_id_valid_nxt = 1'b0;
    end else begin
      w_id_valid_nxt = r_id_valid;
    end
  end

  // State, PC, IF/ID and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= BOOT;
      r_pc       <= RESET_PC;
      r_id_pc    <= 32'h0000_0000;
      r_id_inst  <= NOP_INST;
      r_id_valid <= 1'b0;
      r_halted   <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_id_pc    <= w_id_pc_nxt;
      r_id_inst  <= w_id_inst_nxt;
      r_id_valid <= w_id_valid_nxt;
      r_halted   <= (w_state_nxt == HALT);
      r_fault    <= (w_state_nxt == FAULT);
    end
  end

  assign pc          = r_pc;
  assign id_pc       = r_id_pc;
  assign id_inst     = r_id_inst;
  assign id_valid    = r_id_valid;
  assign halted      = r_halted;
  assign fetch_fault = r_fault;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations, then randomized stall/redirect/reset traffic compared every
// cycle against a behavioural model of the fetch rules.
module tb_fetch_stage;

  localparam int IMEM_BYTES = 40;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        halted;
  logic        fetch_fault;

  int vectors;
  int miscompares;

  logic [31:0] mem [0:9];

  // Model state: mode 0=boot 1=run 2=halt 3=fault
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_id_pc;
  logic [31:0] m_id_inst;
  logic        m_id_valid;

  fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_BYTES(IMEM_BYTES)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .inst(inst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid),
    .halted(halted), .fetch_fault(fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] imem_rd(input logic [31:0] a);
    if (a < 32'(IMEM_BYTES) && a[1:0] == 2'b00) return mem[a[5:2]];
    return 32'hDEAD_BEEF;
  endfunction

  // Combinational IMEM read of whatever the DUT currently drives.
  always_comb inst = imem_rd(pc);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("pc", pc, m_pc);
    chk("id_pc", id_pc, m_id_pc);
    chk("id_inst", id_inst, m_id_inst);
    chk("id_valid", {31'd0, id_valid}, {31'd0, m_id_valid});
    chk("halted", {31'd0, halted}, {31'd0, (m_mode == 2)});
    chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, (m_mode == 3)});
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = 32'h0; m_id_pc = 32'h0; m_id_inst = NOP; m_id_valid = 1'b0;
  endtask

  task automatic model_bubble();
    m_id_inst = NOP; m_id_valid = 1'b0;
  endtask

  // One clock edge of the fetch rules.
  task automatic model_step(input logic st, input logic rv, input logic [31:0] rt);
    if (m_mode == 0) begin
      model_bubble(); m_mode = 1;
    end else if (m_mode == 1) begin
      if (rv) begin
        model_bubble();
        if (rt % 4 == 0) m_pc = rt; else m_mode = 3;
      end else if (!st) begin
        if (m_pc <= 32'(IMEM_BYTES - 4)) begin
          m_id_pc = m_pc; m_id_inst = imem_rd(m_pc); m_id_valid = 1'b1;
          m_pc = m_pc + 32'd4;
        end else begin
          model_bubble(); m_mode = 2;
        end
      end
    end else if (m_mode == 2) begin
      model_bubble();
      if (rv) begin
        if (rt % 4 == 0) begin m_pc = rt; m_mode = 1; end
        else m_mode = 3;
      end
    end else begin
      model_bubble();
    end
  endtask

  task automatic tick(input logic st, input logic rv, input logic [31:0] rt);
    stall = st; redirect_valid = rv; redirect_target = rt;
    if (rst_n) model_step(st, rv, rt);
    @(posedge clk); #1;
    compare_all();
  endtask

  // Drop reset mid-cycle, check the asynchronous effect, hold one edge, release.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk); #1;
    compare_all();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    case ($urandom_range(0, 5))
      0, 1: t = {26'd0, 4'($urandom_range(0, 9)), 2'b00};
      2: t = {26'd0, 4'($urandom_range(0, 9)), 2'($urandom_range(1, 3))};
      3: t = 32'h0000_0028;
      4: t = 32'hFFFF_FFFC;
      default: t = 32'h0000_0000;
    endcase
    return t;
  endfunction

  initial begin
    vectors = 0; miscompares = 0;
    for (int i = 0; i < 10; i++) mem[i] = 32'hA000_0000 + 32'(i);
    mem[0] = 32'h0088_A783;
    mem[1] = 32'h0017_9793;
    mem[6] = 32'h00F7_88B3;
    stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    rst_n = 1'b0;
    model_reset();

    // 1. Reset release
    @(posedge clk); @(posedge clk); #1;
    compare_all();
    chk("rst_id_inst", id_inst, 32'h0000_0013);
    rst_n = 1'b1;
    tick(1'b0, 1'b1, 32'h0000_0018);   // redirect in BOOT is ignored
    chk("e1_pc", pc, 32'h0);
    chk("e1_valid", {31'd0, id_valid}, 32'd0);
    tick(1'b0, 1'b0, 32'h0);
    chk("e2_id_pc", id_pc, 32'h0);
    chk("e2_id_inst", id_inst, 32'h0088_A783);
    chk("e2_valid", {31'd0, id_valid}, 32'd1);
    chk("e2_pc", pc, 32'h4);
    tick(1'b0, 1'b0, 32'h0);
    chk("e3_id_inst", id_inst, 32'h0017_9793);

    // 2. Stall at pc=8
    tick(1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 32'h0);
    chk("stall_pc", pc, 32'h8);
    chk("stall_id_pc", id_pc, 32'h4);
    chk("stall_valid", {31'd0, id_valid}, 32'd1);
    tick(1'b0, 1'b0, 32'h0);
    chk("resume_id_pc", id_pc, 32'h8);
    chk("resume_pc", pc, 32'hC);

    // 3. Redirect with stall
    tick(1'b1, 1'b1, 32'h0000_0018);
    chk("redir_pc", pc, 32'h18);
    chk("redir_valid", {31'd0, id_valid}, 32'd0);
    chk("redir_inst", id_inst, 32'h13);
    tick(1'b0, 1'b0, 32'h0);
    chk("redir_id_pc", id_pc, 32'h18);
    chk("redir_id_inst", id_inst, 32'h00F7_88B3);

    // 4. Run off the end
    begin
      int n;
      n = 0;
      while (m_pc != 32'h28 && n < 20) begin
        tick(1'b0, 1'b0, 32'h0);
        n++;
      end
      chk("runoff_reached", m_pc, 32'h28);
    end
    tick(1'b0, 1'b0, 32'h0);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_pc", pc, 32'h28);
    tick(1'b1, 1'b0, 32'h0);
    chk("halt_valid", {31'd0, id_valid}, 32'd0);
    tick(1'b0, 1'b1, 32'h0);
    chk("unhalt_flag", {31'd0, halted}, 32'd0);
    chk("unhalt_pc", pc, 32'h0);
    tick(1'b0, 1'b0, 32'h0);
    chk("refetch_inst", id_inst, 32'h0088_A783);

    // 5. Misaligned redirect
    tick(1'b0, 1'b1, 32'h0000_001A);
    chk("fault_flag", {31'd0, fetch_fault}, 32'd1);
    tick(1'b0, 1'b1, 32'h0);
    chk("fault_pc_held", pc, 32'h4);
    chk("fault_valid", {31'd0, id_valid}, 32'd0);
    tick(1'b0, 1'b0, 32'h0);
    do_reset();
    chk("fault_cleared", {31'd0, fetch_fault}, 32'd0);

    // 6. Async reset mid-run at pc=0xC
    begin
      int n;
      n = 0;
      while (m_pc != 32'hC && n < 20) begin
        tick(1'b0, 1'b0, 32'h0);
        n++;
      end
      chk("midrun_reached", pc, 32'hC);
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_pc", pc, 32'h0);
    chk("async_id_pc", id_pc, 32'h0);
    chk("async_id_inst", id_inst, 32'h13);
    chk("async_valid", {31'd0, id_valid}, 32'd0);
    @(posedge clk); #1;
    compare_all();
    rst_n = 1'b1;

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        tick(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), rand_target());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
